fb_rect_writer: RTL and testbench
=================================

# fb_rect_writer

Framebuffer fill engine on the write port of the 320x240, 12-bit frame memory that the VGA display path reads. It accepts rectangle-fill and full-clear commands over a valid/ready handshake, clips them to the framebuffer, and issues one pixel write per clock in row-major order. Upstream game/scene logic draws through this block; it is the only writer of the frame memory.

## Interface
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- ADDR_W, 17, write address width (covers FB_W*FB_H = 76800)
- PIX_W, 12, pixel width {R[3:0],G[3:0],B[3:0]}

- clk  in  1  system clock; one clock domain, all logic on posedge clk
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_clear  in  1  1: fill whole frame, ignore x0/y0/w/h
- cmd_x0  in  9  left column
- cmd_y0  in  8  top row
- cmd_w  in  9  width in pixels
- cmd_h  in  8  height in pixels
- cmd_color  in  PIX_W  fill colour
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  linear address y*FB_W + x
- wr_data  out  PIX_W  pixel value
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE: cmd_ready=1. cmd_valid&&cmd_ready at a clock edge latches all cmd_* fields and moves to SETUP. cmd_valid while not IDLE is ignored; it is not queued.
- SETUP (1 cycle): clip the rectangle. x_end=min(x0+w, FB_W), y_end=min(y0+h, FB_H), computed at 10-bit width (no overflow). Clear forces x0=0, y0=0, x_end=FB_W, y_end=FB_H. The rectangle is empty if w==0, h==0, x0>=FB_W or y0>=FB_H. Empty goes to DONE; otherwise load row_base=y0*FB_W+x0 and go to FILL. The multiply is allowed only here.
- FILL: each cycle register wr_en=1, wr_addr=current address and wr_data=latched colour, then advance x.
  - At x==x_end-1: next address = row_base+FB_W, row_base updates, x returns to the clipped x0, y increments.
  - After the write at (x_end-1, y_end-1) go to DONE.
  - Address stepping uses adders only.
- DONE (1 cycle): done=1, wr_en=0, then IDLE.
- busy=1 in SETUP, FILL and DONE.
- Reset (rst=0), including mid-FILL: state is IDLE at once (asynchronous); wr_en, busy and done are 0; wr_addr and wr_data are 0; cmd_ready=1. The partial fill is abandoned.

## Timing
- Command accepted at edge N: SETUP during cycle N..N+1. The first wr_en is visible after edge N+2.
- Writes are back-to-back, one per cycle, with no gaps at row boundaries. A clipped cw x ch rectangle gives exactly cw*ch consecutive wr_en cycles.
- done is high in the cycle after the last write. cmd_ready is high the cycle after done. A new command can be accepted on that edge.
- Empty command: accepted at N, SETUP, done after edge N+2, no writes.
- Full clear: 76800 writes, latency from acceptance to done = 2+76800 cycles.
- wr_en, wr_addr and wr_data are registered and change together. wr_addr never exceeds FB_W*FB_H-1.

## Test plan
- Reset: hold rst=0 -> wr_en=0, busy=0, done=0, wr_addr=0, cmd_ready=1. Release -> still idle with no writes.
- Basic rect: x0=10, y0=5, w=3, h=2, color=0xF00 -> addresses 1610, 1611, 1612, 1930, 1931, 1932 on 6 consecutive cycles, all data 0xF00. done pulses once on the next cycle; cmd_ready returns 1 a cycle later.
- Clipping: x0=318, y0=239, w=5, h=4, color=0x0F0 -> exactly 2 writes, at 76798 and 76799, then done.
- Empty: w=0 (and separately x0=400) -> zero wr_en cycles; done 2 cycles after acceptance.
- Clear: cmd_clear=1, color=0x00F -> 76800 writes with addresses 0..76799 strictly incrementing and no gaps. cmd_valid pulsed during the fill is not accepted; no extra writes follow.
- Reset mid-FILL: assert rst=0 after 100 writes of a clear -> wr_en drops without waiting for an edge. After release, the basic rect command produces the exact sequence from the basic rect scenario.

Source files
------------

// File: rtl/fb_rect_writer.sv
// Rectangle fill / full clear engine. It writes one pixel per clock, in row-major order,
// to the framebuffer write port.
module fb_rect_writer #(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_clear,
    input  logic [8:0]        cmd_x0,
    input  logic [7:0]        cmd_y0,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_d;
    logic              cmd_ready_d, busy_d, done_d, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [PIX_W-1:0]  wr_data_d;

    // Latched command fields
    logic              clr_q, clr_d;
    logic [8:0]        x0_q, x0_d, w_q, w_d;
    logic [7:0]        y0_q, y0_d, h_q, h_d;
    logic [PIX_W-1:0]  color_q, color_d;

    // Scan state
    logic [8:0]        x_start, x_start_d, x_end, x_end_d, x, x_d;
    logic [7:0]        y_end, y_end_d, y, y_d;
    logic [ADDR_W-1:0] row_base, row_base_d, addr, addr_d;

    // Clipping arithmetic. The sums are 10 bits wide, so x0+w and y0+h cannot wrap.
    logic [9:0]        x_sum, y_sum;
    logic [8:0]        x_end_clip;
    logic [7:0]        y_end_clip;
    logic              rect_empty;
    logic [ADDR_W-1:0] row_base_init;

    assign x_sum         = 10'(x0_q) + 10'(w_q);
    assign y_sum         = 10'(y0_q) + 10'(h_q);
    assign x_end_clip    = (x_sum > 10'(FB_W)) ? 9'(FB_W) : 9'(x_sum);
    assign y_end_clip    = (y_sum > 10'(FB_H)) ? 8'(FB_H) : 8'(y_sum);
    assign rect_empty    = (w_q == 9'd0) || (h_q == 8'd0) ||
                           (x0_q >= 9'(FB_W)) || (y0_q >= 8'(FB_H));
    assign row_base_init = ADDR_W'(y0_q) * ADDR_W'(FB_W) + ADDR_W'(x0_q);

    // Next state, next registered outputs and datapath updates
    always_comb begin
        state_d     = state;
        cmd_ready_d = cmd_ready;
        busy_d      = busy;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        clr_d       = clr_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x_start_d   = x_start;
        x_end_d     = x_end;
        y_end_d     = y_end;
        x_d         = x;
        y_d         = y;
        row_base_d  = row_base;
        addr_d      = addr;

        // The handshake reopens on the cycle after the done pulse.
        if (done) begin
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    clr_d       = cmd_clear;
                    x0_d        = cmd_x0;
                    y0_d        = cmd_y0;
                    w_d         = cmd_w;
                    h_d         = cmd_h;
                    color_d     = cmd_color;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (clr_q) begin
                    x_start_d  = 9'd0;
                    x_end_d    = 9'(FB_W);
                    y_end_d    = 8'(FB_H);
                    x_d        = 9'd0;
                    y_d        = 8'd0;
                    row_base_d = '0;
                    addr_d     = '0;
                    state_d    = S_FILL;
                end else if (rect_empty) begin
                    state_d = S_DONE;
                end else begin
                    x_start_d  = x0_q;
                    x_end_d    = x_end_clip;
                    y_end_d    = y_end_clip;
                    x_d        = x0_q;
                    y_d        = y0_q;
                    row_base_d = row_base_init;
                    addr_d     = row_base_init;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr;
                wr_data_d = color_q;
                if (x == x_end - 9'd1) begin
                    if (y == y_end - 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d     = row_base + ADDR_W'(FB_W);
                        row_base_d = row_base + ADDR_W'(FB_W);
                        x_d        = x_start;
                        y_d        = y + 8'd1;
                    end
                end else begin
                    addr_d = addr + ADDR_W'(1);
                    x_d    = x + 9'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            clr_q     <= 1'b0;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            x_start   <= '0;
            x_end     <= '0;
            y_end     <= '0;
            x         <= '0;
            y         <= '0;
            row_base  <= '0;
            addr      <= '0;
        end else begin
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            clr_q     <= clr_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            color_q   <= color_d;
            x_start   <= x_start_d;
            x_end     <= x_end_d;
            y_end     <= y_end_d;
            x         <= x_d;
            y         <= y_d;
            row_base  <= row_base_d;
            addr      <= addr_d;
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer. Each command pushes its expected pixels onto a
// scoreboard queue, and every write is popped from it and compared.
module tb_fb_rect_writer;

    localparam int unsigned FB_W   = 320;
    localparam int unsigned FB_H   = 240;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned PIX_W  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_clear;
    logic [8:0]        cmd_x0, cmd_w;
    logic [7:0]        cmd_y0, cmd_h;
    logic [PIX_W-1:0]  cmd_color;
    logic              wr_en, busy, done;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } pix_t;

    pix_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   wr_count    = 0;
    int   acc_cyc     = 0;

    fb_rect_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge and score any write seen there
    task automatic tick();
        pix_t e;
        @(negedge clk);
        cyc++;
        if (wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic push_pix(input int a, input logic [PIX_W-1:0] col);
        pix_t p;
        p.addr = ADDR_W'(a);
        p.data = col;
        exp_q.push_back(p);
    endtask

    // Reference clip and scan of a command
    task automatic model(input logic clr, input int x0, input int y0, input int w, input int h,
                         input logic [PIX_W-1:0] col, output int n);
        int xs, ys, xe, ye;
        n = 0;
        if (clr) begin
            xs = 0; ys = 0; xe = FB_W; ye = FB_H;
        end else begin
            xs = x0; ys = y0;
            xe = (x0 + w > int'(FB_W)) ? int'(FB_W) : x0 + w;
            ye = (y0 + h > int'(FB_H)) ? int'(FB_H) : y0 + h;
            if (w == 0 || h == 0 || x0 >= int'(FB_W) || y0 >= int'(FB_H)) begin
                xe = xs; ye = ys;
            end
        end
        for (int yy = ys; yy < ye; yy++)
            for (int xx = xs; xx < xe; xx++) begin
                push_pix(yy * int'(FB_W) + xx, col);
                n++;
            end
    endtask

    // Offer a command once cmd_ready is up; acceptance happens at the next rising edge
    task automatic send(input logic clr, input int x0, input int y0, input int w, input int h,
                        input logic [PIX_W-1:0] col);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        chk("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_clear = clr;
        cmd_x0    = 9'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = col;
        cmd_valid = 1'b1;
        wr_count  = 0;
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int n);
        int guard = 0;
        while (done !== 1'b1 && guard < 80000) begin
            tick();
            guard++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(2 + n));
        chk({tag, "_writes"}, 32'(wr_count), 32'(n));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_wr_en_at_done"}, 32'(wr_en), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_ready_after_done"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int guard;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_wr_count", 32'(wr_count), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic rectangle, expected addresses written out directly
        push_pix(1610, 12'hF00); push_pix(1611, 12'hF00); push_pix(1612, 12'hF00);
        push_pix(1930, 12'hF00); push_pix(1931, 12'hF00); push_pix(1932, 12'hF00);
        send(1'b0, 10, 5, 3, 2, 12'hF00);
        wait_done("basic", 6);

        // Bottom-right clipping
        push_pix(76798, 12'h0F0); push_pix(76799, 12'h0F0);
        send(1'b0, 318, 239, 5, 4, 12'h0F0);
        wait_done("clip", 2);

        // Empty commands
        model(1'b0, 5, 5, 0, 3, 12'h123, n);
        send(1'b0, 5, 5, 0, 3, 12'h123);
        wait_done("empty_w", n);
        model(1'b0, 400, 5, 4, 3, 12'h456, n);
        send(1'b0, 400, 5, 4, 3, 12'h456);
        wait_done("empty_x0", n);
        model(1'b0, 7, 9, 4, 0, 12'h789, n);
        send(1'b0, 7, 9, 4, 0, 12'h789);
        wait_done("empty_h", n);
        model(1'b0, 7, 250, 4, 3, 12'hABC, n);
        send(1'b0, 7, 250, 4, 3, 12'hABC);
        wait_done("empty_y0", n);

        // Interior rectangle spanning several rows
        model(1'b0, 100, 50, 7, 5, 12'h5A5, n);
        send(1'b0, 100, 50, 7, 5, 12'h5A5);
        wait_done("mid_rect", n);

        // Full clear; a command offered mid-fill must be ignored
        model(1'b1, 0, 0, 0, 0, 12'h00F, n);
        send(1'b1, 0, 0, 0, 0, 12'h00F);
        repeat (50) tick();
        cmd_clear = 1'b0;
        cmd_x0 = 9'd10; cmd_y0 = 8'd5; cmd_w = 9'd3; cmd_h = 8'd2; cmd_color = 12'hFFF;
        cmd_valid = 1'b1;
        repeat (4) tick();
        cmd_valid = 1'b0;
        wait_done("clear", n);
        repeat (10) tick();
        chk("clear_no_extra_writes", 32'(wr_count), 32'(n));
        chk("clear_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a clear
        model(1'b1, 0, 0, 0, 0, 12'h0AA, n);
        send(1'b1, 0, 0, 0, 0, 12'h0AA);
        guard = 0;
        while (wr_count < 100 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("midfill_writes_before_rst", 32'(wr_count), 32'd100);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("async_rst_wr_data", 32'(wr_data), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_writes", 32'(wr_count), 32'd100);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Basic rectangle again after the abandoned fill
        push_pix(1610, 12'hF00); push_pix(1611, 12'hF00); push_pix(1612, 12'hF00);
        push_pix(1930, 12'hF00); push_pix(1931, 12'hF00); push_pix(1932, 12'hF00);
        send(1'b0, 10, 5, 3, 2, 12'hF00);
        wait_done("basic_after_rst", 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
